// File: rtl/iq_cic_decim.sv
// Dual-channel (I/Q) 3-stage CIC decimator, R = 2^LOG2_DECIM.
// Both channels share one control path: decimation counter, strobe and
// priming. Integrators wrap modulo 2^ACC_W by design.
module iq_cic_decim #(
  parameter int IN_W       = 12,
  parameter int LOG2_DECIM = 3,
  parameter int OUT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i_in,
  input  logic [IN_W-1:0]  q_in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] i_out,
  output logic [OUT_W-1:0] q_out,
  output logic             out_valid
);

  localparam int ACC_W = IN_W + 3 * LOG2_DECIM;
  localparam int SHIFT = ACC_W - OUT_W;

  logic [ACC_W-1:0]      x_ext  [2];
  logic [ACC_W-1:0]      integ1 [2];
  logic [ACC_W-1:0]      integ2 [2];
  logic [ACC_W-1:0]      integ3 [2];
  logic [ACC_W-1:0]      s0     [2];
  logic [ACC_W-1:0]      c1     [2];
  logic [ACC_W-1:0]      c2     [2];
  logic [ACC_W-1:0]      d1     [2];
  logic [ACC_W-1:0]      d2     [2];
  logic [ACC_W-1:0]      d3     [2];
  logic [OUT_W-1:0]      c3     [2];
  logic                  v0, v1, v2, v3;
  logic [LOG2_DECIM-1:0] dec_cnt;
  logic [1:0]            prime_cnt;
  logic                  strobe;

  // Sign-extend inputs to accumulator width; strobe on the R-th valid input.
  always_comb begin
    x_ext[0] = ACC_W'($signed(i_in));
    x_ext[1] = ACC_W'($signed(q_in));
    strobe   = in_valid && (&dec_cnt);
  end

  // Integrators, decimation sampling, comb pipeline, output scaling and priming.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        integ1[ch] <= '0;
        integ2[ch] <= '0;
        integ3[ch] <= '0;
        s0[ch]     <= '0;
        c1[ch]     <= '0;
        c2[ch]     <= '0;
        c3[ch]     <= '0;
        d1[ch]     <= '0;
        d2[ch]     <= '0;
        d3[ch]     <= '0;
      end
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      dec_cnt   <= '0;
      prime_cnt <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        dec_cnt <= dec_cnt + 1'b1;
      end
      v0 <= strobe;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        if (in_valid) begin
          integ1[ch] <= integ1[ch] + x_ext[ch];
          integ2[ch] <= integ2[ch] + integ1[ch];
          integ3[ch] <= integ3[ch] + integ2[ch];
        end
        if (strobe) begin
          s0[ch] <= integ3[ch];
        end
        if (v0) begin
          c1[ch] <= s0[ch] - d1[ch];
          d1[ch] <= s0[ch];
        end
        if (v1) begin
          c2[ch] <= c1[ch] - d2[ch];
          d2[ch] <= c1[ch];
        end
        // Last comb stage keeps only the top OUT_W bits: floor by 3*LOG2_DECIM.
        if (v2) begin
          c3[ch] <= OUT_W'((c2[ch] - d3[ch]) >> SHIFT);
          d3[ch] <= c2[ch];
        end
      end
      out_valid <= v3 && (prime_cnt == 2'd3);
      if (v3) begin
        i_out <= c3[0];
        q_out <= c3[1];
        if (prime_cnt != 2'd3) begin
          prime_cnt <= prime_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iq_cic_decim.sv
// Self-checking bench for iq_cic_decim: one default instance (R=8) and one
// R=2 instance, checked every cycle against a convolution-based CIC model.
module tb_iq_cic_decim;

  logic        clk;
  logic        rst;
  logic [11:0] i_in0, q_in0, i_in1, q_in1;
  logic        in_valid0, in_valid1;
  logic [11:0] i_out0, q_out0, i_out1, q_out1;
  logic        out_valid0, out_valid1;

  iq_cic_decim u0 (
    .clk(clk), .rst(rst), .i_in(i_in0), .q_in(q_in0), .in_valid(in_valid0),
    .i_out(i_out0), .q_out(q_out0), .out_valid(out_valid0)
  );

  iq_cic_decim #(.LOG2_DECIM(1)) u1 (
    .clk(clk), .rst(rst), .i_in(i_in1), .q_in(q_in1), .in_valid(in_valid1),
    .i_out(i_out1), .q_out(q_out1), .out_valid(out_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state per instance (index 0: R=8, index 1: R=2)
  int xi [2][0:8191];
  int xq [2][0:8191];
  int strobe_at [2][0:4095];
  int kern [2][0:31];
  int nv [2];
  int nk [2];
  bit known [2];
  int ei [2];
  int eq [2];
  int ovc [2];
  int first_ov [2];
  int rel_cyc [2];

  function automatic int rdec(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic int rs();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  function automatic int fs4i(input int t);
    case (t % 4)
      1: return 100;
      3: return -100;
      default: return 0;
    endcase
  endfunction

  function automatic int fs4q(input int t);
    case (t % 4)
      0: return 100;
      2: return -100;
      default: return 0;
    endcase
  endfunction

  // Build the impulse response of three cascaded length-R boxcars.
  task automatic build_kernel(input int d);
    int a [0:31];
    int b [0:31];
    int r = rdec(d);
    for (int n = 0; n < 32; n++) a[n] = 0;
    a[0] = 1;
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 32; n++) begin
        b[n] = 0;
        for (int m = 0; m < r; m++) if (n - m >= 0) b[n] += a[n - m];
      end
      for (int n = 0; n < 32; n++) a[n] = b[n];
    end
    for (int n = 0; n < 32; n++) kern[d][n] = a[n];
  endtask

  // Result k: the newest contributing sample is valid input number k*R-4
  // (0-based); output is the kernel-weighted sum divided (floor) by R^3.
  function automatic int model_out(input int d, input int k, input bit qch);
    longint y = 0;
    int r = rdec(d);
    int sh = (d == 0) ? 9 : 3;
    int newest = k * r - 4;
    for (int j = newest; j >= 0 && j > newest - (3 * r - 2); j--) begin
      y += longint'(qch ? xq[d][j] : xi[d][j]) * longint'(kern[d][newest - j]);
    end
    return int'(y >>> sh);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int d);
    int oi, oq, due;
    bit ov;
    string t;
    t = (d == 0) ? "r8" : "r2";
    if (d == 0) begin
      oi = int'($signed(i_out0)); oq = int'($signed(q_out0)); ov = out_valid0;
    end else begin
      oi = int'($signed(i_out1)); oq = int'($signed(q_out1)); ov = out_valid1;
    end
    due = 0;
    for (int k = nk[d]; k >= 1 && k >= nk[d] - 4; k--) begin
      if (strobe_at[d][k] + 4 == cyc) due = k;
    end
    chk({t, ".out_valid"}, int'(ov), int'(due >= 4));
    if (due >= 4) begin
      known[d] = 1'b1;
      ei[d] = model_out(d, due, 1'b0);
      eq[d] = model_out(d, due, 1'b1);
    end else if (due != 0) begin
      known[d] = 1'b0;
    end
    if (known[d]) begin
      chk({t, ".i_out"}, oi, ei[d]);
      chk({t, ".q_out"}, oq, eq[d]);
    end
    if (ov) begin
      ovc[d]++;
      if (first_ov[d] < 0) first_ov[d] = cyc - rel_cyc[d];
    end
  endtask

  task automatic step(input bit r, input bit v0, input int i0, input int q0,
                      input bit v1, input int i1, input int q1);
    bit vv;
    rst = r;
    in_valid0 = v0; i_in0 = 12'(i0); q_in0 = 12'(q0);
    in_valid1 = v1; i_in1 = 12'(i1); q_in1 = 12'(q1);
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      vv = (d == 0) ? v0 : v1;
      if (r) begin
        nv[d] = 0; nk[d] = 0; known[d] = 1'b1; ei[d] = 0; eq[d] = 0;
        ovc[d] = 0; first_ov[d] = -1; rel_cyc[d] = cyc;
      end else if (vv) begin
        xi[d][nv[d]] = (d == 0) ? i0 : i1;
        xq[d][nv[d]] = (d == 0) ? q0 : q1;
        nv[d]++;
        if (nv[d] % rdec(d) == 0) begin
          nk[d]++;
          strobe_at[d][nk[d]] = cyc;
        end
      end
    end
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    build_kernel(0);
    build_kernel(1);
    for (int d = 0; d < 2; d++) begin
      nv[d] = 0; nk[d] = 0; known[d] = 1'b0; ovc[d] = 0; first_ov[d] = -1; rel_cyc[d] = 0;
    end
    rst = 1'b1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    i_in0 = '0; q_in0 = '0; i_in1 = '0; q_in1 = '0;

    // Reset, then DC +100/-50 on R=8 and DC +7/-7 on R=2
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 80; t++) step(0, 1, 100, -50, 1, 7, -7);
    chk("r8.first_out_valid_edge", first_ov[0], 36);

    // fs/4 quadrature pattern
    for (int t = 0; t < 64; t++) step(0, 1, fs4i(t), fs4q(t), 1, fs4i(t), fs4q(t));

    // Full scale held
    for (int t = 0; t < 64; t++) step(0, 1, -2048, 2047, 1, 2047, -2048);

    // in_valid toggling with +300
    for (int t = 0; t < 96; t++) step(0, (t % 2) == 0, 300, -300, (t % 2) == 0, 300, 1);

    // Random data with random gaps
    for (int t = 0; t < 200; t++)
      step(0, $urandom_range(3) != 0, rs(), rs(), $urandom_range(3) != 0, rs(), rs());

    // Reset landing on an R=8 strobe edge
    for (int t = 0; t < 16 && (nv[0] % 8) != 7; t++) step(0, 1, rs(), rs(), 1, rs(), rs());
    step(1, 1, rs(), rs(), 1, rs(), rs());
    for (int t = 0; t < 60; t++) step(0, 1, rs(), rs(), 1, rs(), rs());
    chk("r8.first_out_valid_after_rst", first_ov[0], 36);

    // R=2 continuous DC +7: no dropped strobes over the run
    step(1, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 220; t++) step(0, $urandom_range(1) != 0, rs(), rs(), 1, 7, 7);
    chk("r2.out_valid_count", ovc[1], 105);
    chk("r2.first_out_valid_edge", first_ov[1], 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
